calc_bcd: RTL and testbench

CALC_BCD -- requirements
Module: calc_bcd

---
 rtl/calc_pkg.sv | 52 +++++
 rtl/key_sync.sv | 47 ++++
 rtl/calc_bcd.sv | 182 ++++++++++++++++++
 tb/tb_calc_bcd.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : calc_pkg                                                |
// | Purpose  : Shared types and sizing helpers for the BCD calculator  |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
package calc_pkg;

   typedef enum logic [2:0] {
      ENTRY_A = 3'd0,
      OP_WAIT = 3'd1,
      ENTRY_B = 3'd2,
      RESULT  = 3'd3,
      ERR     = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2
   } op_e;

   // Bit positions of the keys inside the synchronised key vector
   localparam int KEY_W     = 15;
   localparam int KEY_PLUS  = 10;
   localparam int KEY_MINUS = 11;
   localparam int KEY_TIMES = 12;
   localparam int KEY_EQ    = 13;
   localparam int KEY_CE    = 14;

   // Largest displayable magnitude, 10^digits - 1
   function automatic int calc_max(input int digits);
      int r;
      r = 1;
      for (int i = 0; i < digits; i++) r = r * 10;
      return r - 1;
   endfunction

   // Bits needed for an unsigned magnitude up to calc_max
   function automatic int calc_mag_width(input int digits);
      return $clog2(calc_max(digits) + 1);
   endfunction

   // Signed arithmetic width that holds +/-MAX*MAX without wrapping
   function automatic int calc_width(input int digits);
      int m;
      m = calc_max(digits);
      return $clog2(m * m + 1) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/key_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : key_sync                                                |
// | Purpose  : 2-flop synchroniser plus rising-edge pulse per key      |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module key_sync #(
   parameter int WIDTH = 15
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] key_i,
   output logic [WIDTH-1:0] pulse_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] armed_q;
   logic [1:0]       settle_q;

   // Synchronise, remember previous level, and arm each key only once it has
   // been seen released after the pipeline settles out of reset, so a key held
   // through reset never produces a press.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q   <= '0;
         sync_q   <= '0;
         prev_q   <= '0;
         armed_q  <= '0;
         settle_q <= 2'd0;
      end else begin
         meta_q <= key_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
         if (settle_q != 2'd2) begin
            settle_q <= settle_q + 2'd1;
         end else begin
            armed_q <= armed_q | ~sync_q;
         end
      end
   end

   assign pulse_o = sync_q & ~prev_q & armed_q;

endmodule
`default_nettype wire

// File: rtl/calc_bcd.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : calc_bcd                                                |
// | Purpose  : Keypad-driven signed decimal calculator, BCD display    |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module calc_bcd
   import calc_pkg::*;
#(
   parameter int DIGITS = 2,
   parameter bit MUL_EN = 1'b1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [9:0]            push,
   input  logic                  plus,
   input  logic                  minus,
   input  logic                  times,
   input  logic                  equal,
   input  logic                  ce,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  sign,
   output logic                  overflow
);

   localparam int MAX = calc_max(DIGITS);
   localparam int MW  = calc_mag_width(DIGITS);
   localparam int AW  = calc_width(DIGITS);
   localparam int LIM = (MAX + 1) / 10;
   localparam logic signed [AW-1:0] MAX_S = AW'(MAX);

   logic [KEY_W-1:0] keys_raw;
   logic [KEY_W-1:0] pulse;

   logic       is_ce, is_eq, is_op, is_dig;
   op_e        op_sel;
   logic [3:0] dig;

   state_e                 state_q;
   op_e                    op_q;
   logic signed [AW-1:0]   acc_q;
   logic [MW-1:0]          entry_q;
   logic [MW-1:0]          disp_q;
   logic                   sign_q;
   logic                   ovf_q;

   logic signed [AW-1:0]   entry_s, mag_s, disp_s, res_d;
   logic [MW-1:0]          entry_d, mag_d, acc_mag;
   logic                   res_ovf;
   logic [MW-1:0]          bcd_rem;

   // The times key is forced low when multiplication is disabled
   assign keys_raw = {ce, equal, (MUL_EN ? times : 1'b0), minus, plus, push};

   key_sync #(.WIDTH(KEY_W)) u_key_sync (
      .clk_i   (CLK),
      .rst_i   (RST),
      .key_i   (keys_raw),
      .pulse_o (pulse)
   );

   // Resolve simultaneous key pulses into a single event by priority
   always_comb begin
      is_ce  = pulse[KEY_CE];
      is_eq  = ~pulse[KEY_CE] & pulse[KEY_EQ];
      is_op  = ~pulse[KEY_CE] & ~pulse[KEY_EQ] & (|pulse[KEY_TIMES:KEY_PLUS]);
      is_dig = ~(|pulse[KEY_CE:KEY_PLUS]) & (|pulse[9:0]);
      op_sel = pulse[KEY_PLUS]  ? OP_ADD :
               pulse[KEY_MINUS] ? OP_SUB : OP_MUL;
      dig    = 4'd0;
      for (int i = 9; i >= 0; i--) begin
         if (pulse[i]) dig = 4'(i);
      end
   end

   // Candidate values: appended entry, signed display, pending-op result
   always_comb begin
      entry_s = $signed({{(AW-MW){1'b0}}, entry_q});
      mag_s   = $signed({{(AW-MW){1'b0}}, disp_q});
      disp_s  = sign_q ? -mag_s : mag_s;
      entry_d = entry_q * MW'(10) + MW'(dig);
      case (op_q)
         OP_ADD:  res_d = acc_q + entry_s;
         OP_SUB:  res_d = acc_q - entry_s;
         default: res_d = acc_q * entry_s;
      endcase
      res_ovf = (res_d > MAX_S) || (res_d < -MAX_S);
      mag_d   = MW'(res_d[AW-1] ? -res_d : res_d);
      acc_mag = MW'(acc_q[AW-1] ? -acc_q : acc_q);
   end

   // Calculator state machine; display magnitude and sign are registered here
   always_ff @(posedge CLK) begin
      if (RST || is_ce) begin
         state_q <= ENTRY_A;
         op_q    <= OP_ADD;
         acc_q   <= '0;
         entry_q <= '0;
         disp_q  <= '0;
         sign_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            ENTRY_A, ENTRY_B: begin
               if (is_eq || is_op) begin
                  if (state_q == ENTRY_A) begin
                     if (is_eq) begin
                        disp_q  <= entry_q;
                        sign_q  <= 1'b0;
                        state_q <= RESULT;
                     end else begin
                        acc_q   <= disp_s;
                        op_q    <= op_sel;
                        state_q <= OP_WAIT;
                     end
                  end else if (res_ovf) begin
                     state_q <= ERR;
                     ovf_q   <= 1'b1;
                     disp_q  <= '0;
                     sign_q  <= 1'b0;
                  end else begin
                     acc_q   <= res_d;
                     disp_q  <= mag_d;
                     sign_q  <= res_d[AW-1];
                     state_q <= is_eq ? RESULT : OP_WAIT;
                     if (is_op) op_q <= op_sel;
                  end
               end else if (is_dig && (entry_q < MW'(LIM))) begin
                  // Leading zeros keep entry below LIM, so they never use up a digit slot
                  entry_q <= entry_d;
                  disp_q  <= entry_d;
                  sign_q  <= 1'b0;
               end
            end
            OP_WAIT: begin
               if (is_eq) begin
                  disp_q  <= acc_mag;
                  sign_q  <= acc_q[AW-1];
                  state_q <= RESULT;
               end else if (is_op) begin
                  op_q <= op_sel;
               end else if (is_dig) begin
                  entry_q <= MW'(dig);
                  disp_q  <= MW'(dig);
                  sign_q  <= 1'b0;
                  state_q <= ENTRY_B;
               end
            end
            RESULT: begin
               if (is_op) begin
                  acc_q   <= disp_s;
                  op_q    <= op_sel;
                  state_q <= OP_WAIT;
               end else if (is_dig) begin
                  entry_q <= MW'(dig);
                  disp_q  <= MW'(dig);
                  sign_q  <= 1'b0;
                  state_q <= ENTRY_A;
               end
            end
            default: begin
               // ERR: only ce (handled above) leaves this state
            end
         endcase
      end
   end

   // Binary-to-BCD conversion of the registered display magnitude
   always_comb begin
      bcd     = '0;
      bcd_rem = disp_q;
      for (int i = 0; i < DIGITS; i++) begin
         bcd[4*i +: 4] = 4'(bcd_rem % MW'(10));
         bcd_rem       = bcd_rem / MW'(10);
      end
   end

   assign sign     = sign_q;
   assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_bcd.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_calc_bcd                                             |
// | Purpose  : Directed self-checking bench for calc_bcd (DIGITS=2)    |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tb_calc_bcd;

   localparam int K_PLUS  = 10;
   localparam int K_MINUS = 11;
   localparam int K_TIMES = 12;
   localparam int K_EQ    = 13;
   localparam int K_CE    = 14;

   logic        CLK = 1'b0;
   logic        RST;
   logic [14:0] key_r;
   logic [7:0]  bcd;
   logic        sign;
   logic        overflow;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 CLK = ~CLK;

   calc_bcd #(.DIGITS(2), .MUL_EN(1'b1)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .push     (key_r[9:0]),
      .plus     (key_r[K_PLUS]),
      .minus    (key_r[K_MINUS]),
      .times    (key_r[K_TIMES]),
      .equal    (key_r[K_EQ]),
      .ce       (key_r[K_CE]),
      .bcd      (bcd),
      .sign     (sign),
      .overflow (overflow)
   );

   task automatic press(input int k);
      @(negedge CLK);
      key_r[k] = 1'b1;
      repeat (3) @(negedge CLK);
      key_r[k] = 1'b0;
      repeat (3) @(negedge CLK);
   endtask

   task automatic press2(input int a, input int b);
      @(negedge CLK);
      key_r[a] = 1'b1;
      key_r[b] = 1'b1;
      repeat (3) @(negedge CLK);
      key_r[a] = 1'b0;
      key_r[b] = 1'b0;
      repeat (3) @(negedge CLK);
   endtask

   task automatic check(input string tag, input logic [7:0] eb, input logic es, input logic eo);
      n_tests++;
      assert (bcd === eb && sign === es && overflow === eo)
      else begin
         n_fail++;
         $error("FAIL %s: got bcd=%h sign=%b ovf=%b, expected bcd=%h sign=%b ovf=%b",
                tag, bcd, sign, overflow, eb, es, eo);
      end
   endtask

   initial begin
      RST   = 1'b1;
      key_r = '0;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      repeat (4) @(negedge CLK);
      check("reset", 8'h00, 1'b0, 1'b0);

      // Entry limited to two significant digits
      press(4); press(2);
      check("entry_42", 8'h42, 1'b0, 1'b0);
      press(7);
      check("entry_full_ignored", 8'h42, 1'b0, 1'b0);

      // Leading zero does not consume a digit
      press(K_CE); press(0);
      check("leading_zero", 8'h00, 1'b0, 1'b0);
      press(5);
      check("after_leading_zero", 8'h05, 1'b0, 1'b0);

      // 42 + 7 = 49, repeated equal ignored
      press(K_CE); press(4); press(2); press(K_PLUS);
      check("op_wait_shows_acc", 8'h42, 1'b0, 1'b0);
      press(7);
      check("entry_b", 8'h07, 1'b0, 1'b0);
      press(K_EQ);
      check("add_49", 8'h49, 1'b0, 1'b0);
      press(K_EQ);
      check("equal_in_result", 8'h49, 1'b0, 1'b0);

      // 15 - 40 = -25, then -25 - 5 = -30
      press(K_CE); press(1); press(5); press(K_MINUS); press(4); press(0); press(K_EQ);
      check("sub_neg25", 8'h25, 1'b1, 1'b0);
      press(K_MINUS); press(5); press(K_EQ);
      check("chain_from_result_neg30", 8'h30, 1'b1, 1'b0);

      // Chaining: 3 + 4 + -> 7, then 5 = -> 12, then 9 x 11 = 99
      press(K_CE); press(3); press(K_PLUS); press(4); press(K_PLUS);
      check("chain_7", 8'h07, 1'b0, 1'b0);
      press(5); press(K_EQ);
      check("chain_12", 8'h12, 1'b0, 1'b0);
      press(9); press(K_TIMES); press(1); press(1); press(K_EQ);
      check("mul_99", 8'h99, 1'b0, 1'b0);

      // Overflow: 60 + 50 = 110 > 99
      press(K_CE); press(6); press(0); press(K_PLUS); press(5); press(0); press(K_EQ);
      check("overflow", 8'h00, 1'b0, 1'b1);
      press(3);
      check("err_ignores_digit", 8'h00, 1'b0, 1'b1);
      press(K_CE);
      check("ce_clears_err", 8'h00, 1'b0, 1'b0);
      press(8);
      check("entry_a_after_ce", 8'h08, 1'b0, 1'b0);

      // Operator beats digit in the same cycle
      press(K_CE); press(3); press2(K_PLUS, 5);
      check("plus_beats_digit", 8'h03, 1'b0, 1'b0);
      press(2);
      check("entry_b_after_prio", 8'h02, 1'b0, 1'b0);
      press(K_EQ);
      check("prio_sum_5", 8'h05, 1'b0, 1'b0);

      // Lowest digit wins among simultaneous digits
      press(K_CE); press2(7, 3);
      check("lowest_digit_wins", 8'h03, 1'b0, 1'b0);

      // Two-cycle latency from first sample to output
      press(K_CE);
      @(negedge CLK);
      key_r[9] = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      check("latency_not_yet", 8'h00, 1'b0, 1'b0);
      @(negedge CLK);
      check("latency_k_plus_2", 8'h09, 1'b0, 1'b0);
      key_r[9] = 1'b0;
      repeat (3) @(negedge CLK);

      // Reset mid-entry clears everything on the next edge
      press(K_CE); press(4); press(1);
      check("pre_reset_41", 8'h41, 1'b0, 1'b0);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      check("reset_mid_entry", 8'h00, 1'b0, 1'b0);
      RST = 1'b0;
      repeat (4) @(negedge CLK);

      // Key held through reset must be released before it counts
      key_r[6] = 1'b1;
      @(negedge CLK);
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      repeat (6) @(negedge CLK);
      check("held_through_reset", 8'h00, 1'b0, 1'b0);
      key_r[6] = 1'b0;
      repeat (4) @(negedge CLK);
      check("held_released", 8'h00, 1'b0, 1'b0);
      press(6);
      check("held_repressed", 8'h06, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
